// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared constants and command type for the two-port memory
//               arbiter (FSM encoding, size codes, port indices).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [1:0] SIZE_BYTE      = 2'd0;
    localparam logic [1:0] SIZE_HALF      = 2'd1;
    localparam logic [1:0] SIZE_UNALIGNED = 2'd2;
    localparam logic [1:0] SIZE_WORD      = 2'd3;

    localparam int P0_IDX = 0;
    localparam int P1_IDX = 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_rr
// Description : Two-port winner selection with last-grant pointer.
//               MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 first).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = &{1'b0, clock, reset, advance};

    always_comb begin
        grant = 2'b00;
        if (req[P0_IDX])
            grant[P0_IDX] = 1'b1;
        else if (req[P1_IDX])
            grant[P1_IDX] = 1'b1;
    end
`else
    // 1 = port 1 was granted last, so port 0 wins the next tie
    logic r_last;

    always_ff @(posedge clock) begin
        if (reset)
            r_last <= 1'b1;
        else if (advance && (|grant))
            r_last <= grant[P1_IDX];
    end

    always_comb begin
        grant = 2'b00;
        if (req[P0_IDX] && req[P1_IDX])
            grant = r_last ? 2'b01 : 2'b10;
        else if (req[P0_IDX])
            grant[P0_IDX] = 1'b1;
        else if (req[P1_IDX])
            grant[P1_IDX] = 1'b1;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port arbiter onto a single data memory; one access per
//               three cycles (IDLE/ACCESS/RESP). Build option:
//               MEM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [15:0] MEM_ADDR = 16'h1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [1:0]  p0_size,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [1:0]  p1_size,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [1:0]  w_req;
    logic [1:0]  w_grant;
    logic        w_advance;
    cmd_t        w_sel_cmd;
    cmd_t        r_cmd;
    logic [1:0]  r_winner;
    logic [31:0] r_resp;
    logic        w_cmd_valid;

    assign w_req     = {p1_req, p0_req};
    assign w_advance = (r_state == ST_IDLE);
    assign w_sel_cmd = w_grant[P1_IDX] ? cmd_t'{p1_we, p1_addr, p1_wdata, p1_size}
                                       : cmd_t'{p0_we, p0_addr, p0_wdata, p0_size};

    // Out-of-window or unaligned commands still run the full sequence, silently
    assign w_cmd_valid = (r_cmd.addr[31:16] == MEM_ADDR) && (r_cmd.size != SIZE_UNALIGNED);

    mem_arb_rr u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     (w_req),
        .advance (w_advance),
        .grant   (w_grant)
    );

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (|w_req) w_next_state = ST_ACCESS;
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cmd    <= '0;
            r_winner <= 2'b00;
            r_resp   <= 32'h0;
        end else begin
            if ((r_state == ST_IDLE) && (|w_req)) begin
                r_cmd    <= w_sel_cmd;
                r_winner <= w_grant;
            end
            if (r_state == ST_ACCESS)
                r_resp <= (w_cmd_valid && !r_cmd.we) ? mem_rdata : 32'h0;
        end
    end

    always_comb begin
        mem_addr  = r_cmd.addr;
        mem_wdata = r_cmd.wdata;
        mem_size  = r_cmd.size;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        p0_ack    = 1'b0;
        p1_ack    = 1'b0;
        p0_rdata  = 32'h0;
        p1_rdata  = 32'h0;
        if ((r_state == ST_ACCESS) && w_cmd_valid) begin
            mem_we = r_cmd.we;
            mem_re = !r_cmd.we;
        end
        if (r_state == ST_RESP) begin
            p0_ack = r_winner[P0_IDX];
            p1_ack = r_winner[P1_IDX];
            if (r_winner[P0_IDX]) p0_rdata = r_resp;
            if (r_winner[P1_IDX]) p1_rdata = r_resp;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter with a falling-edge memory.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [1:0]  p0_size, p1_size;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
    logic        mem_we, mem_re;

    mem_arbiter #(.MEM_ADDR(16'h1000)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_size(p0_size), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_size(p1_size), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Data memory: samples its command on the falling edge
    logic [31:0] mem [0:255];
    always @(negedge clock) begin
        if (reset)
            mem[1] <= 32'h11223344;
        if (mem_we)
            mem[mem_addr[9:2]] <= mem_wdata;
        if (mem_re)
            mem_rdata <= mem[mem_addr[9:2]];
    end

    typedef struct {
        logic [31:0] port;
        logic [31:0] rdata;
    } ack_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } mem_exp_t;

    ack_exp_t ack_q[$];
    mem_exp_t mem_q[$];
    ack_exp_t mon_a;
    mem_exp_t mon_m;
    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (p0_ack || p1_ack) begin
            check("ack_exclusive", {31'b0, p0_ack & p1_ack}, 32'h0);
            if (ack_q.size() == 0) begin
                check("unexpected_ack", {30'b0, p1_ack, p0_ack}, 32'h0);
            end else begin
                mon_a = ack_q.pop_front();
                check("ack_port", {31'b0, p1_ack}, mon_a.port);
                check("ack_rdata", p1_ack ? p1_rdata : p0_rdata, mon_a.rdata);
            end
        end
        if (mem_we || mem_re) begin
            if (mem_q.size() == 0) begin
                check("unexpected_mem_cmd", {30'b0, mem_we, mem_re}, 32'h0);
            end else begin
                mon_m = mem_q.pop_front();
                check("mem_we", {31'b0, mem_we}, {31'b0, mon_m.we});
                check("mem_re", {31'b0, mem_re}, {31'b0, !mon_m.we});
                check("mem_addr", mem_addr, mon_m.addr);
                check("mem_size", {30'b0, mem_size}, {30'b0, mon_m.size});
                if (mon_m.we)
                    check("mem_wdata", mem_wdata, mon_m.wdata);
            end
        end
    end

    task automatic drive(int port, logic req, logic we, logic [31:0] addr,
                         logic [31:0] wdata, logic [1:0] size);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_size = size;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_size = size;
        end
    endtask

    function automatic logic ack_of(int port);
        return (port == 0) ? p0_ack : p1_ack;
    endfunction

    task automatic expect_access(int port, logic we, logic [31:0] addr, logic [31:0] wdata,
                                 logic [1:0] size, logic [31:0] rdata, logic hits_mem);
        ack_q.push_back('{port: 32'(port), rdata: rdata});
        if (hits_mem)
            mem_q.push_back('{we: we, addr: addr, wdata: wdata, size: size});
    endtask

    task automatic access(int port, logic we, logic [31:0] addr, logic [31:0] wdata,
                          logic [1:0] size, logic [31:0] rdata, logic hits_mem);
        int n;
        @(posedge clock); #1;
        expect_access(port, we, addr, wdata, size, rdata, hits_mem);
        drive(port, 1'b1, we, addr, wdata, size);
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!ack_of(port) && n < 20);
        // request cycle counts as cycle 1
        check("latency", 32'(n + 1), 32'd3);
        drive(port, 1'b0, 1'b0, addr, 32'h0, size);
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_p0_ack"}, {31'b0, p0_ack}, 32'h0);
        check({tag, "_p1_ack"}, {31'b0, p1_ack}, 32'h0);
        check({tag, "_p0_rdata"}, p0_rdata, 32'h0);
        check({tag, "_p1_rdata"}, p1_rdata, 32'h0);
        check({tag, "_mem_we"}, {31'b0, mem_we}, 32'h0);
        check({tag, "_mem_re"}, {31'b0, mem_re}, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_mem_size"}, {30'b0, mem_size}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, last, k;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, SIZE_BYTE);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, SIZE_BYTE);
        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;

        access(0, 1'b0, 32'h1000_0004, 32'h0, SIZE_WORD, 32'h1122_3344, 1'b1);
        access(1, 1'b1, 32'h1000_0010, 32'hCAFE_BABE, SIZE_WORD, 32'h0, 1'b1);
        access(1, 1'b0, 32'h1000_0010, 32'h0, SIZE_WORD, 32'hCAFE_BABE, 1'b1);
        access(1, 1'b0, 32'h1000_0004, 32'h0, SIZE_BYTE, 32'h1122_3344, 1'b1);
        access(0, 1'b1, 32'h2000_0000, 32'hDEAD_BEEF, SIZE_WORD, 32'h0, 1'b0);
        access(0, 1'b0, 32'h1000_0004, 32'h0, SIZE_UNALIGNED, 32'h0, 1'b0);

        // Reset during the ACCESS cycle of a p0 read aborts it without an ack
        @(posedge clock); #1;
        mem_q.push_back('{we: 1'b0, addr: 32'h1000_0004, wdata: 32'h0, size: SIZE_WORD});
        drive(0, 1'b1, 1'b0, 32'h1000_0004, 32'h0, SIZE_WORD);
        @(posedge clock); #1;
        check("abort_in_access", {31'b0, mem_re}, 32'h1);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, SIZE_BYTE);
        @(posedge clock); #1;
        reset = 1'b0;
        check_idle_outputs("abort");
        repeat (4) @(posedge clock);
        access(0, 1'b0, 32'h1000_0004, 32'h0, SIZE_WORD, 32'h1122_3344, 1'b1);

        // Both ports from reset, each wanting two reads
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        expect_access(0, 1'b0, 32'h1000_0004, 32'h0, SIZE_WORD, 32'h1122_3344, 1'b1);
        expect_access(0, 1'b0, 32'h1000_0004, 32'h0, SIZE_WORD, 32'h1122_3344, 1'b1);
        expect_access(1, 1'b0, 32'h1000_0010, 32'h0, SIZE_WORD, 32'hCAFE_BABE, 1'b1);
        expect_access(1, 1'b0, 32'h1000_0010, 32'h0, SIZE_WORD, 32'hCAFE_BABE, 1'b1);
`else
        expect_access(0, 1'b0, 32'h1000_0004, 32'h0, SIZE_WORD, 32'h1122_3344, 1'b1);
        expect_access(1, 1'b0, 32'h1000_0010, 32'h0, SIZE_WORD, 32'hCAFE_BABE, 1'b1);
        expect_access(0, 1'b0, 32'h1000_0004, 32'h0, SIZE_WORD, 32'h1122_3344, 1'b1);
        expect_access(1, 1'b0, 32'h1000_0010, 32'h0, SIZE_WORD, 32'hCAFE_BABE, 1'b1);
`endif
        drive(0, 1'b1, 1'b0, 32'h1000_0004, 32'h0, SIZE_WORD);
        drive(1, 1'b1, 1'b0, 32'h1000_0010, 32'h0, SIZE_WORD);
        n0 = 0; n1 = 0; last = -1; k = 0;
        while (!(n0 == 2 && n1 == 2) && k < 40) begin
            @(posedge clock); #1;
            k++;
            if (p0_ack || p1_ack) begin
                if (last >= 0)
                    check("ack_spacing", 32'(k - last), 32'd3);
                last = k;
            end
            if (p0_ack) begin
                n0++;
                if (n0 == 2) drive(0, 1'b0, 1'b0, 32'h1000_0004, 32'h0, SIZE_WORD);
            end
            if (p1_ack) begin
                n1++;
                if (n1 == 2) drive(1, 1'b0, 1'b0, 32'h1000_0010, 32'h0, SIZE_WORD);
            end
        end
        check("concurrent_done", {31'b0, (n0 == 2 && n1 == 2)}, 32'h1);

        repeat (3) @(posedge clock);
        #1;
        check("ack_q_empty", 32'(ack_q.size()), 32'h0);
        check("mem_q_empty", 32'(mem_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
